// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side drain stage for a FIFO.
// Pops bytes through the FIFO read port, which has one cycle of read latency.
// It packs PACK_RATIO consecutive bytes into one wide word, with the first byte
// in the least significant lane. Each word is offered downstream on a
// valid/ready handshake.
// Optional feature macro: PACK_FLUSH_EN adds a flush input. Flush closes a
// partially filled word and reports the number of filled lanes in out_bytes.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_r_data,
    output logic                             fifo_rd_en,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [CNT_WIDTH-1:0]             out_bytes,
    output logic                             out_valid,
    input  logic                             out_ready
`ifdef PACK_FLUSH_EN
   ,input  logic                             flush
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH:0]   RATIO_EXT = (CNT_WIDTH + 1)'(PACK_RATIO);
    localparam logic [CNT_WIDTH-1:0] RATIO_CNT = CNT_WIDTH'(PACK_RATIO);

    state_t                            state;
    logic [CNT_WIDTH-1:0]              cnt;
    logic                              pend;
    logic [CNT_WIDTH:0]                inflight;
    logic [CNT_WIDTH-1:0]              cnt_next;
    logic [DATA_WIDTH*PACK_RATIO-1:0]  word_next;
    logic                              flush_req;

    // Bytes already captured plus the byte still on its way from the FIFO.
    // One extra bit prevents the sum from wrapping.
    assign inflight = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, pend};
    assign cnt_next = cnt + CNT_WIDTH'(pend);

`ifdef PACK_FLUSH_EN
    // A flush counts only while filling a word that already holds some data.
    // A flush on an empty word, or while a word is held, does nothing.
    assign flush_req = flush && (state == FILL) && (inflight != '0);
`else
    assign flush_req = 1'b0;
`endif

    // Pop only while filling, when the FIFO has data and the word still has a free lane.
    // Popping stops while a flush closes the word. It is forced low during reset.
    always_comb begin
        fifo_rd_en = rst_n && (state == FILL) && !fifo_empty &&
                     (inflight < RATIO_EXT) && !flush_req;
    end

    // Merge the arriving byte into the lane chosen by the capture count.
    always_comb begin
        word_next = out_data;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (pend && (cnt == CNT_WIDTH'(k))) begin
                word_next[k*DATA_WIDTH +: DATA_WIDTH] = fifo_r_data;
            end
        end
    end

    // Capture/hold state machine.
    // The last capture, or a flush, moves to HOLD on the same edge and raises out_valid.
    // A downstream accept clears the word and returns to FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            pend      <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            out_valid <= 1'b0;
        end else begin
            pend <= fifo_rd_en;
            case (state)
                FILL: begin
                    if (pend) begin
                        out_data <= word_next;
                        cnt      <= cnt_next;
                    end
                    if ((cnt_next == RATIO_CNT) || flush_req) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_bytes <= cnt_next;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= FILL;
                        cnt       <= '0;
                        out_data  <= '0;
                        out_bytes <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: self-checking bench for fifo_rd_packer (DATA_WIDTH=8, PACK_RATIO=4).
// A simple array-based FIFO with one cycle of read latency drives the DUT.
// Each word accepted downstream is compared with words built from the fed bytes.
// The flush scenario is compiled only when PACK_FLUSH_EN is defined.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PR = 4;
    localparam int CW = $clog2(PR + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_r_data = '0;
    logic            fifo_rd_en;
    logic [DW*PR-1:0] out_data;
    logic [CW-1:0]   out_bytes;
    logic            out_valid;
    logic            out_ready = 1'b0;
`ifdef PACK_FLUSH_EN
    logic            flush = 1'b0;
`endif

    int tests_run = 0;
    int fails = 0;

    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    int cycle = 0;
    int underflow = 0;
    int valid_cycles = 0;
    logic [31:0] got_data[$];
    int          got_bytes[$];
    int          hs_cycle[$];

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_rd_en  (fifo_rd_en),
        .out_data    (out_data),
        .out_bytes   (out_bytes),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef PACK_FLUSH_EN
       ,.flush       (flush)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: an entry popped at an edge shows up on r_data after that edge.
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_r_data <= mem[rd_ptr % 1024];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    // Monitor: count cycles, flag underflow attempts, record accepted words.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (fifo_rd_en && fifo_empty) underflow = underflow + 1;
        if (out_valid) valid_cycles = valid_cycles + 1;
        if (rst_n && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_bytes.push_back(int'(out_bytes));
            hs_cycle.push_back(cycle);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_sb();
        got_data.delete();
        got_bytes.delete();
        hs_cycle.delete();
        valid_cycles = 0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int t;
        t = 0;
        while (got_data.size() < n && t < budget) begin
            step();
            t++;
        end
    endtask

    task automatic test_reset();
        int hi;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: valid=%b rd_en=%b expected 0/0", out_valid, fifo_rd_en);
        end
        tests_run++;
        if (out_data !== '0 || out_bytes !== '0) begin
            fails++;
            $display("[TB] FAIL reset_data: data=%h bytes=%0d expected 0/0", out_data, out_bytes);
        end
        step(); step();
        rst_n = 1'b1;
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (fifo_rd_en) hi++;
        end
        tests_run++;
        if (hi != 0) begin
            fails++;
            $display("[TB] FAIL reset_idle_rd_en: high %0d cycles expected 0", hi);
        end
        step();
    endtask

    task automatic test_basic_pack();
        int start;
        clear_sb();
        start = rd_ptr;
        out_ready = 1'b1;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        wait_words(1, 30);
        repeat (5) step();
        tests_run++;
        if (got_data.size() != 1) begin
            fails++;
            $display("[TB] FAIL basic_count: got %0d words expected 1", got_data.size());
        end
        tests_run++;
        if ((got_data.size() > 0 ? got_data[0] : 32'hxxxxxxxx) !== 32'h44332211) begin
            fails++;
            $display("[TB] FAIL basic_data: got %h expected 44332211", got_data.size() > 0 ? got_data[0] : 32'hx);
        end
        tests_run++;
        if ((got_bytes.size() > 0 ? got_bytes[0] : -1) != 4) begin
            fails++;
            $display("[TB] FAIL basic_bytes: got %0d expected 4", got_bytes.size() > 0 ? got_bytes[0] : -1);
        end
        tests_run++;
        if (valid_cycles != 1) begin
            fails++;
            $display("[TB] FAIL basic_valid_width: got %0d cycles expected 1", valid_cycles);
        end
        tests_run++;
        if (rd_ptr - start != 4) begin
            fails++;
            $display("[TB] FAIL basic_pops: got %0d expected 4", rd_ptr - start);
        end
    endtask

    task automatic test_backpressure();
        int start;
        int unstable;
        bit seen;
        logic [31:0] held;
        clear_sb();
        start = rd_ptr;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_byte(8'(i * 8'h11));
        seen = 1'b0;
        unstable = 0;
        held = '0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                held = out_data;
            end else if (seen && (!out_valid || out_data !== held || out_bytes !== 3'(PR))) begin
                unstable++;
            end
        end
        step();
        tests_run++;
        if (rd_ptr - start != 4) begin
            fails++;
            $display("[TB] FAIL bp_pops_held: got %0d expected 4", rd_ptr - start);
        end
        tests_run++;
        if (!seen || held !== 32'h44332211 || unstable != 0) begin
            fails++;
            $display("[TB] FAIL bp_hold: seen=%b data=%h unstable=%0d expected 1/44332211/0", seen, held, unstable);
        end
        out_ready = 1'b1;
        wait_words(2, 40);
        repeat (3) step();
        tests_run++;
        if (got_data.size() != 2) begin
            fails++;
            $display("[TB] FAIL bp_count: got %0d words expected 2", got_data.size());
        end
        tests_run++;
        if ((got_data.size() > 1 ? got_data[1] : 32'hx) !== 32'h88776655 ||
            (got_data.size() > 0 ? got_data[0] : 32'hx) !== 32'h44332211) begin
            fails++;
            $display("[TB] FAIL bp_data: got %h,%h expected 44332211,88776655",
                     got_data.size() > 0 ? got_data[0] : 32'hx, got_data.size() > 1 ? got_data[1] : 32'hx);
        end
        tests_run++;
        if (rd_ptr - start != 8) begin
            fails++;
            $display("[TB] FAIL bp_pops_total: got %0d expected 8", rd_ptr - start);
        end
    endtask

    task automatic test_async_reset();
        int t;
        int hi;
        out_ready = 1'b0;
        push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3); push_byte(8'hD4);
        t = 0;
        while (!out_valid && t < 30) begin
            step();
            t++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL async_pre_valid: got %b expected 1", out_valid);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_bytes !== '0 || fifo_rd_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset: valid=%b data=%h bytes=%0d rd_en=%b expected all 0",
                     out_valid, out_data, out_bytes, fifo_rd_en);
        end
        step();
        rst_n = 1'b1;
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (fifo_rd_en) hi++;
        end
        tests_run++;
        if (hi != 0) begin
            fails++;
            $display("[TB] FAIL async_idle_rd_en: high %0d cycles expected 0", hi);
        end
        step();
    endtask

    task automatic test_reset_mid_word();
        out_ready = 1'b1;
        push_byte(8'hAA); push_byte(8'hBB);
        repeat (5) step();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        clear_sb();
        push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
        wait_words(1, 30);
        repeat (4) step();
        tests_run++;
        if (got_data.size() != 1 || got_data[0] !== 32'h88776655) begin
            fails++;
            $display("[TB] FAIL mid_reset_word: count=%0d data=%h expected 1/88776655",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 32'hx);
        end
    endtask

    task automatic test_empty_gaps();
        logic [7:0] bytes_q[$];
        logic [31:0] exp_w[4];
        int gap;
        int bad;
        clear_sb();
        underflow = 0;
        for (int i = 0; i < 16; i++) begin
            bytes_q.push_back(8'($urandom_range(0, 255)));
            push_byte(bytes_q[i]);
            gap = $urandom_range(1, 10);
            repeat (gap) begin
                step();
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        for (int w = 0; w < 4; w++) begin
            exp_w[w] = '0;
            for (int k = 0; k < 4; k++) exp_w[w] = exp_w[w] | (32'(bytes_q[w*4 + k]) << (8 * k));
        end
        out_ready = 1'b1;
        wait_words(4, 60);
        step();
        tests_run++;
        if (got_data.size() != 4) begin
            fails++;
            $display("[TB] FAIL gaps_count: got %0d words expected 4", got_data.size());
        end
        for (int w = 0; w < 4; w++) begin
            tests_run++;
            if ((got_data.size() > w ? got_data[w] : 32'hx) !== exp_w[w]) begin
                fails++;
                $display("[TB] FAIL gaps_word%0d: got %h expected %h", w,
                         got_data.size() > w ? got_data[w] : 32'hx, exp_w[w]);
            end
        end
        bad = 0;
        foreach (got_bytes[i]) if (got_bytes[i] != 4) bad++;
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL gaps_bytes: %0d words with out_bytes != 4, expected 0", bad);
        end
        tests_run++;
        if (underflow != 0) begin
            fails++;
            $display("[TB] FAIL underflow: got %0d pops while empty expected 0", underflow);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) push_byte(8'(8'h20 + i));
        base = cycle + 1;
        wait_words(3, 60);
        step();
        tests_run++;
        if ((hs_cycle.size() > 0 ? hs_cycle[0] - base : -1) != PR + 1) begin
            fails++;
            $display("[TB] FAIL b2b_latency: got %0d cycles expected %0d",
                     hs_cycle.size() > 0 ? hs_cycle[0] - base : -1, PR + 1);
        end
        tests_run++;
        if (hs_cycle.size() < 3 || hs_cycle[1] - hs_cycle[0] != PR + 2 || hs_cycle[2] - hs_cycle[1] != PR + 2) begin
            fails++;
            $display("[TB] FAIL b2b_period: words=%0d gaps=%0d,%0d expected %0d",
                     hs_cycle.size(), hs_cycle.size() > 1 ? hs_cycle[1] - hs_cycle[0] : -1,
                     hs_cycle.size() > 2 ? hs_cycle[2] - hs_cycle[1] : -1, PR + 2);
        end
        tests_run++;
        if ((got_data.size() > 2 ? got_data[2] : 32'hx) !== 32'h2b2a2928) begin
            fails++;
            $display("[TB] FAIL b2b_word2: got %h expected 2b2a2928", got_data.size() > 2 ? got_data[2] : 32'hx);
        end
    endtask

`ifdef PACK_FLUSH_EN
    task automatic test_flush();
        int start;
        clear_sb();
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (5) step();
        tests_run++;
        if (valid_cycles != 0) begin
            fails++;
            $display("[TB] FAIL flush_empty: got %0d valid cycles expected 0", valid_cycles);
        end
        start = rd_ptr;
        push_byte(8'h11); push_byte(8'h22);
        repeat (6) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_words(1, 20);
        step();
        tests_run++;
        if ((got_data.size() > 0 ? got_data[0] : 32'hx) !== 32'h00002211) begin
            fails++;
            $display("[TB] FAIL flush_data: got %h expected 00002211", got_data.size() > 0 ? got_data[0] : 32'hx);
        end
        tests_run++;
        if ((got_bytes.size() > 0 ? got_bytes[0] : -1) != 2 || rd_ptr - start != 2) begin
            fails++;
            $display("[TB] FAIL flush_bytes: got %0d bytes %0d pops expected 2/2",
                     got_bytes.size() > 0 ? got_bytes[0] : -1, rd_ptr - start);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_async_reset();
        test_reset_mid_word();
        test_empty_gaps();
        test_back_to_back();
`ifdef PACK_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
